// File: rtl/norm_recip.sv
// norm_recip: fixed-point reciprocal stage behind the leading-one normalizer.
//   Restoring divider computes floor(2^(2W-1)/mant), one quotient bit per
//   cycle, saturated to W bits; the normalizer shift count passes through.
// Optional feature macro: NORM_RECIP_ROUND_EN (one extra step, round half up).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake (ready only in IDLE)
//   mant_in[W], exp_in[EXPW] normalized mantissa and its shift count
//   out_valid/out_ready      result handshake (held until accepted)
//   recip_out[W], exp_out[EXPW], err  result, passed shift count, zero flag
module norm_recip #(
  parameter int unsigned W    = 10,
  parameter int unsigned EXPW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    mant_in,
  input  logic [EXPW-1:0] exp_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    recip_out,
  output logic [EXPW-1:0] exp_out,
  output logic            err
);

`ifdef NORM_RECIP_ROUND_EN
  localparam int unsigned QW = W + 2;
`else
  localparam int unsigned QW = W + 1;
`endif
  localparam int unsigned CW = $clog2(QW + 1);

  // Dividend 2^(2W-1): the bits above the QW quotient positions form the
  // starting remainder 2^(W-2); every bit shifted in afterwards is zero.
  localparam logic [W:0] REM_INIT = (W+1)'(1) << (W - 2);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_n;
  logic [W:0]      rem, rem_n;
  logic [QW-1:0]   quo, quo_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [W-1:0]    div, div_n;
  logic [EXPW-1:0] exp_q, exp_q_n;
  logic            zero_q, zero_q_n;
  logic            in_ready_n, out_valid_n, err_n;
  logic [W-1:0]    recip_n;
  logic [EXPW-1:0] exp_out_n;

  logic [W:0]      rem_sh_c;
  logic [W+1:0]    diff_c;
  logic            qbit_c;
  logic [QW-1:0]   quo_step_c;

  // Final quotient to W-bit result with saturation (and optional rounding).
  function automatic logic [W-1:0] finish_q(input logic [QW-1:0] q);
`ifdef NORM_RECIP_ROUND_EN
    logic [W+1:0] sum;
    sum = {1'b0, q[QW-1:1]} + (W+2)'(q[0]);
    return (|sum[W+1:W]) ? {W{1'b1}} : sum[W-1:0];
`else
    return q[W] ? {W{1'b1}} : q[W-1:0];
`endif
  endfunction

  // One restoring step: shift in a zero dividend bit, trial subtract.
  always_comb begin
    rem_sh_c   = {rem[W-1:0], 1'b0};
    diff_c     = {1'b0, rem_sh_c} - {2'b00, div};
    qbit_c     = ~diff_c[W+1];
    quo_step_c = {quo[QW-2:0], qbit_c};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    rem_n     = rem;
    quo_n     = quo;
    cnt_n     = cnt;
    div_n     = div;
    exp_q_n   = exp_q;
    zero_q_n  = zero_q;
    recip_n   = recip_out;
    exp_out_n = exp_out;
    err_n     = err;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          div_n    = mant_in;
          exp_q_n  = exp_in;
          zero_q_n = (mant_in == '0);
          rem_n    = REM_INIT;
          quo_n    = '0;
          cnt_n    = CW'(QW);
          state_n  = BUSY;
        end
      end
      BUSY: begin
        rem_n = qbit_c ? diff_c[W:0] : rem_sh_c;
        quo_n = quo_step_c;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n   = DONE;
          recip_n   = zero_q ? {W{1'b1}} : finish_q(quo_step_c);
          exp_out_n = exp_q;
          err_n     = zero_q;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      div       <= '0;
      exp_q     <= '0;
      zero_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      recip_out <= '0;
      exp_out   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      quo       <= quo_n;
      cnt       <= cnt_n;
      div       <= div_n;
      exp_q     <= exp_q_n;
      zero_q    <= zero_q_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      recip_out <= recip_n;
      exp_out   <= exp_out_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_norm_recip.sv
// tb_norm_recip: directed self-checking bench for norm_recip (W=10, EXPW=5).
module tb_norm_recip;

  localparam int unsigned W    = 10;
  localparam int unsigned EXPW = 5;
`ifdef NORM_RECIP_ROUND_EN
  localparam int unsigned LAT   = 12;
  localparam int unsigned R768  = 683;
  localparam int unsigned R1023 = 513;
  localparam int unsigned R600  = 874;
`else
  localparam int unsigned LAT   = 11;
  localparam int unsigned R768  = 682;
  localparam int unsigned R1023 = 512;
  localparam int unsigned R600  = 873;
`endif
  localparam int unsigned R640  = 819;
  localparam int unsigned PERIOD = LAT + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    mant_in;
  logic [EXPW-1:0] exp_in;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    recip_out;
  logic [EXPW-1:0] exp_out;
  logic            err;

  int unsigned ncmp  = 0;
  int unsigned nfail = 0;

  norm_recip #(.W(W), .EXPW(EXPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_in   (mant_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .recip_out (recip_out),
    .exp_out   (exp_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int unsigned m, input int unsigned e);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("accept_ready", 32'(in_ready), 1);
    mant_in  = W'(m);
    exp_in   = EXPW'(e);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int unsigned lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(out_valid), 0);
    chk({tag, "_drain_ready"}, 32'(in_ready), 1);
  endtask

  task automatic op(input string tag, input int unsigned m, input int unsigned e,
                    input int unsigned er, input int unsigned ee);
    int unsigned lat;
    accept(m, e);
    wait_done(lat);
    chk({tag, "_lat"},   lat, LAT);
    chk({tag, "_recip"}, 32'(recip_out), er);
    chk({tag, "_exp"},   32'(exp_out), e);
    chk({tag, "_err"},   32'(err), ee);
    drain(tag);
  endtask

  initial begin
    int unsigned lat;
    int unsigned held;
    int unsigned ops_m [3];
    int unsigned ops_r [3];
    int unsigned acc_cyc [3];
    int unsigned a, r;
    logic acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mant_in = '0; exp_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_recip",     32'(recip_out), 0);
    chk("rst_exp",       32'(exp_out), 0);
    chk("rst_err",       32'(err), 0);

    // Basic operands, saturation and zero mantissa
    op("m768",  768,  3, R768,  0);
    op("m512",  512,  1, 1023,  0);
    op("m1023", 1023, 2, R1023, 0);
    op("m0",    0,    9, 1023,  1);

    // Hold in DONE with out_ready low; a new operand must be ignored
    accept(600, 7);
    wait_done(lat);
    chk("hold_lat", lat, LAT);
    mant_in = W'(700); exp_in = EXPW'(5); in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_ready", 32'(in_ready), 0);
      chk("hold_recip", 32'(recip_out), R600);
      chk("hold_exp",   32'(exp_out), 7);
    end
    in_valid = 1'b0;
    drain("hold");
    held = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) held++;
    end
    chk("hold_no_ghost", held, 0);

    // Reset in the 4th BUSY cycle discards the operation
    accept(768, 2);
    tick(); tick(); tick();
    chk("rstmid_busy", 32'(in_ready), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_valid", 32'(out_valid), 0);
    chk("rstmid_ready", 32'(in_ready), 1);
    chk("rstmid_recip", 32'(recip_out), 0);
    chk("rstmid_exp",   32'(exp_out), 0);
    op("m640", 640, 4, R640, 0);

    // Back-to-back operands with in_valid and out_ready held high
    ops_m = '{768, 1023, 640};
    ops_r = '{R768, R1023, R640};
    acc_cyc = '{0, 0, 0};
    a = 0; r = 0;
    mant_in = W'(ops_m[0]); exp_in = EXPW'(1); in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 80 && r < 3; c++) begin
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        if (a < 3) acc_cyc[a] = c;
        a++;
        if (a < 3) begin
          mant_in = W'(ops_m[a]);
          exp_in  = EXPW'(a + 1);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (r < 3) begin
          chk("b2b_recip", 32'(recip_out), ops_r[r]);
          chk("b2b_exp",   32'(exp_out), r + 1);
        end
        r++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", a, 3);
    chk("b2b_results", r, 3);
    chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], PERIOD);
    chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], PERIOD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
